puf_challenge_sequencer: RTL

//  Controller for the PUF mapping datapath. Builds a challenge word serially from the two PUF
//  bit inputs and holds it stable for a settle window. Then pulses the mapping trigger, waits
//  for done with a timeout and returns the captured response. Sits between the board I/O
//  (a/b bits, LEDs or host) and the mapping instance; replaces ad-hoc counter sequencing at top.

---
 rtl/puf_challenge_sequencer_pkg.sv | 23 ++
 rtl/puf_challenge_sequencer_if.sv | 15 +
 rtl/puf_challenge_sequencer_majority3.sv | 11 +
 rtl/puf_challenge_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and defaults for the PUF challenge sequencer: state encoding,
// default widths, vote count and a width helper.
package puf_seq_pkg;
   localparam int DEF_IN_WIDTH       = 128;
   localparam int DEF_OUT_WIDTH      = 16;
   localparam int DEF_SETTLE_CYCLES  = 3;
   localparam int DEF_TIMEOUT_CYCLES = 1024;
   localparam int VOTE_COUNT         = 3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_TRIG   = 3'd3,
      S_WAIT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // Counter width for a limit, never below one bit so a limit of 1 still works.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Sequencer <-> mapping datapath link: challenge/trigger out, done/response back.
interface puf_challenge_sequencer_if
   import puf_seq_pkg::*;
#(
   parameter int IN_WIDTH  = DEF_IN_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH
);
   logic [IN_WIDTH-1:0]  mp_challenge;
   logic                 mp_trigger;
   logic                 mp_done;
   logic [OUT_WIDTH-1:0] mp_response;

   modport master (output mp_challenge, output mp_trigger, input mp_done, input mp_response);
   modport slave  (input mp_challenge, input mp_trigger, output mp_done, output mp_response);
endinterface

// File: rtl/puf_challenge_sequencer_majority3.sv
// Bitwise 3-input majority of PUF responses; used only when PUF_MAJORITY_VOTE_EN is defined.
module puf_majority3 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   output logic [WIDTH-1:0] maj
);
   assign maj = (x & y) | (x & z) | (y & z);
endmodule

// File: rtl/puf_challenge_sequencer.sv
// PUF challenge sequencer: serial challenge load, settle, trigger, bounded wait, capture.
// Optional macro PUF_MAJORITY_VOTE_EN: three evaluations per challenge, majority-voted response.
module puf_challenge_sequencer
   import puf_seq_pkg::*;
#(
   parameter int IN_WIDTH       = DEF_IN_WIDTH,
   parameter int OUT_WIDTH      = DEF_OUT_WIDTH,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     a,
   input  logic                     b,
   puf_challenge_sequencer_if.master mp,
   output logic                     rsp_valid,
   output logic [OUT_WIDTH-1:0]     rsp_data,
   output logic                     busy,
   output logic                     timeout_err
);
   localparam int IDX_W = clog2_min1(IN_WIDTH);
   localparam int SET_W = clog2_min1(SETTLE_CYCLES);
   localparam int TMR_W = clog2_min1(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(IN_WIDTH / 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_WIDTH - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [SET_W-1:0]     set_cnt;
   logic [TMR_W-1:0]     timer;
   logic [IN_WIDTH-1:0]  chal;
   logic                 trig;
   logic                 last_run;
   logic [OUT_WIDTH-1:0] final_rsp;

   assign mp.mp_challenge = chal;
   assign mp.mp_trigger   = trig;

`ifdef PUF_MAJORITY_VOTE_EN
   localparam logic [1:0] RUN_LAST = 2'(VOTE_COUNT - 1);
   logic [1:0]           run;
   logic [OUT_WIDTH-1:0] rsp0;
   logic [OUT_WIDTH-1:0] rsp1;

   // Earlier runs are banked; the last run's response feeds the voter directly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run  <= '0;
         rsp0 <= '0;
         rsp1 <= '0;
      end else if (state == S_IDLE) begin
         run <= '0;
      end else if (state == S_WAIT && mp.mp_done && !last_run) begin
         if (run == 2'd0) rsp0 <= mp.mp_response;
         else             rsp1 <= mp.mp_response;
         run <= run + 2'd1;
      end
   end

   assign last_run = (run == RUN_LAST);

   puf_majority3 #(.WIDTH(OUT_WIDTH)) u_vote (
      .x   (rsp0),
      .y   (rsp1),
      .z   (mp.mp_response),
      .maj (final_rsp)
   );
`else
   assign last_run  = 1'b1;
   assign final_rsp = mp.mp_response;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         set_cnt     <= '0;
         timer       <= '0;
         chal        <= '0;
         trig        <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         trig      <= 1'b0;
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_LOAD;
                  idx         <= '0;
                  busy        <= 1'b1;
                  timeout_err <= 1'b0;
               end
            end
            S_LOAD: begin
               chal[idx] <= (idx < IDX_HALF) ? a : b;
               if (idx == IDX_LAST) begin
                  state   <= S_SETTLE;
                  set_cnt <= '0;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            S_SETTLE: begin
               if (set_cnt == SET_LAST) begin
                  state <= S_TRIG;
                  trig  <= 1'b1;
               end else begin
                  set_cnt <= set_cnt + SET_W'(1);
               end
            end
            S_TRIG: begin
               state <= S_WAIT;
               timer <= '0;
            end
            S_WAIT: begin
               // done is checked first so it wins over a same-cycle timeout
               if (mp.mp_done) begin
                  state <= S_DONE;
                  if (last_run) begin
                     rsp_data  <= final_rsp;
                     rsp_valid <= 1'b1;
                  end
               end else if (timer == TMR_LAST) begin
                  state       <= S_IDLE;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_DONE: begin
               if (last_run) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= S_TRIG;
                  trig  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule
